// File: rtl/aes_batch_ctrl_if.sv
// Handshake and core-side bundle for aes_batch_ctrl.
// slave : controller view (consumes ciphertext/results, produces plaintext/start).
// master: surrounding system view (producer, consumer and AES core).
interface aes_batch_ctrl_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BLK_W = 128
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             MODE;
    logic             IV_LOAD;
    logic [BLK_W-1:0] IV;
    logic             IN_VALID;
    logic             IN_READY;
    logic [BLK_W-1:0] IN_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [BLK_W-1:0] OUT_DATA;
    logic             AES_START;
    logic             AES_DONE;
    logic [BLK_W-1:0] AES_MSG_ENC;
    logic [BLK_W-1:0] AES_MSG_DEC;
    logic             BUSY;
    logic [CNT_W-1:0] IN_COUNT;

    modport slave (
        input  MODE, IV_LOAD, IV, IN_VALID, IN_DATA, OUT_READY, AES_DONE, AES_MSG_DEC,
        output IN_READY, OUT_VALID, OUT_DATA, AES_START, AES_MSG_ENC, BUSY, IN_COUNT
    );

    modport master (
        output MODE, IV_LOAD, IV, IN_VALID, IN_DATA, OUT_READY, AES_DONE, AES_MSG_DEC,
        input  IN_READY, OUT_VALID, OUT_DATA, AES_START, AES_MSG_ENC, BUSY, IN_COUNT
    );
endinterface

// File: rtl/aes_batch_ctrl.sv
// Batch controller for an external AES decrypt core with ECB/CBC chaining.
// Ciphertext blocks queue in an input FIFO, are issued one at a time to the
// core, and the (optionally chained) plaintext queues in an output FIFO.
// Ports: CLK, RESET (sync, active-high), bus (aes_batch_ctrl_if.slave) carrying
// input/output streams, IV/mode load, core start/done/data, BUSY and IN_COUNT.
module aes_batch_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BLK_W = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    aes_batch_ctrl_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE} state_e;

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic [BLK_W-1:0]   msg_enc_q, msg_enc_d;
    logic [BLK_W-1:0]   chain_q, chain_d;
    logic               mode_q, mode_d;
    logic [PTR_W-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [PTR_W-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [BLK_W-1:0]   in_mem_q  [DEPTH];
    logic [BLK_W-1:0]   out_mem_q [DEPTH];

    logic               in_push, launch, out_push, out_pop;
    logic [BLK_W-1:0]   result;

    // Next-state, FIFO bookkeeping and chaining.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        msg_enc_d = msg_enc_q;
        chain_d   = chain_q;
        mode_d    = mode_q;
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        in_cnt_d  = in_cnt_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        launch    = 1'b0;
        out_push  = 1'b0;
        in_push   = bus.IN_VALID && (in_cnt_q != CNT_W'(DEPTH));
        out_pop   = (out_cnt_q != CNT_W'(0)) && bus.OUT_READY;
        result    = mode_q ? (bus.AES_MSG_DEC ^ chain_q) : bus.AES_MSG_DEC;

        case (state_q)
            S_IDLE: begin
                // Nothing is in flight here, so the credit is just output occupancy.
                if ((in_cnt_q != CNT_W'(0)) && (out_cnt_q < CNT_W'(DEPTH))) begin
                    launch    = 1'b1;
                    msg_enc_d = in_mem_q[in_rd_q];
                    start_d   = 1'b1;
                    state_d   = S_RUN;
                end
                // Load only with an empty queue; a same-cycle push sees the new IV.
                if (bus.IV_LOAD && (in_cnt_q == CNT_W'(0))) begin
                    chain_d = bus.IV;
                    mode_d  = bus.MODE;
                end
            end
            S_RUN: begin
                if (bus.AES_DONE) begin
                    out_push = 1'b1;
                    start_d  = 1'b0;
                    state_d  = S_RELEASE;
                    if (mode_q) begin
                        chain_d = msg_enc_q;
                    end
                end
            end
            S_RELEASE: begin
                if (!bus.AES_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (in_push) in_wr_d = in_wr_q + PTR_W'(1);
        if (launch)  in_rd_d = in_rd_q + PTR_W'(1);
        case ({in_push, launch})
            2'b10:   in_cnt_d = in_cnt_q + CNT_W'(1);
            2'b01:   in_cnt_d = in_cnt_q - CNT_W'(1);
            default: ;
        endcase

        if (out_push) out_wr_d = out_wr_q + PTR_W'(1);
        if (out_pop)  out_rd_d = out_rd_q + PTR_W'(1);
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: ;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            msg_enc_q <= '0;
            chain_q   <= '0;
            mode_q    <= 1'b0;
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            msg_enc_q <= msg_enc_d;
            chain_q   <= chain_d;
            mode_q    <= mode_d;
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (!RESET && in_push) begin
            in_mem_q[in_wr_q] <= bus.IN_DATA;
        end
        if (!RESET && out_push) begin
            out_mem_q[out_wr_q] <= result;
        end
    end

    assign bus.IN_READY    = (in_cnt_q != CNT_W'(DEPTH));
    assign bus.OUT_VALID   = (out_cnt_q != CNT_W'(0));
    assign bus.OUT_DATA    = (out_cnt_q != CNT_W'(0)) ? out_mem_q[out_rd_q] : '0;
    assign bus.AES_START   = start_q;
    assign bus.AES_MSG_ENC = msg_enc_q;
    assign bus.IN_COUNT    = in_cnt_q;
    assign bus.BUSY        = (state_q != S_IDLE) || (in_cnt_q != CNT_W'(0)) ||
                             (out_cnt_q != CNT_W'(0));
endmodule
